mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 29, memory word address width; DATA_W, default 32, data width; RETRY_GAP, default 16, number of WAIT cycles before a read is re-issued; MAX_RETRY, default 8, number of re-issues before error.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, all logic posedge.
- rst  in  1  asynchronous, active-high reset.
- d_req  in  1  data-port request; d_we  in  1  1=write, 0=read; d_addr  in  ADDR_W; d_wdata  in  DATA_W.
- d_ready  out  1  request captured; d_rvalid  out  1  read data/err valid; d_rdata  out  DATA_W; d_err  out  1  read failed.
- i_req  in  1  instruction-port read request; i_addr  in  ADDR_W.
- i_ready  out  1; i_rvalid  out  1; i_rdata  out  DATA_W; i_err  out  1 (same meanings as data port).
- mem_en  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_read_req  out  1; mem_write_req  out  1.
- mem_read_valid  in  1; mem_read_data  in  DATA_W; mem_read_ready  in  1; mem_write_ready  in  1; mem_stall  in  1  (memory-side stall).
- busy  out  1  transaction outstanding; timeout_err  out  1  sticky error flag.

Function
REQ-003 The block SHALL allow exactly one outstanding memory transaction; states are IDLE, ISSUE, WAIT.
REQ-004 In IDLE with mem_stall=0, the block SHALL grant one requester: if only one of d_req/i_req is high, that one; if both, the requester not granted last (round-robin via last_grant).
REQ-005 *_ready SHALL be combinational, high only in IDLE for the granted requester; on that edge the block SHALL capture addr, wdata, we (0 for instruction port), owner, and transition to ISSUE.
REQ-006 Requesters SHALL hold req/addr/wdata stable until ready; no requester is granted outside IDLE, and requests pending then are held off (ready=0).
REQ-007 In ISSUE, the block SHALL assert mem_read_req (read) or mem_write_req (write) for exactly one cycle, only when the matching mem_*_ready=1 and mem_stall=0; otherwise it SHALL remain in ISSUE with both strobes low.
REQ-008 A write SHALL complete on its strobe cycle (posted) -> IDLE; a read SHALL move to WAIT with the wait counter cleared.
REQ-009 mem_en SHALL equal busy; mem_addr/mem_wdata SHALL be driven from captured registers whenever busy=1, else 0.
REQ-010 In WAIT, on mem_read_valid=1 the block SHALL register mem_read_data into the owner's rdata, pulse the owner's rvalid for one cycle (err=0) on the next cycle, and go to IDLE.
REQ-011 In WAIT without valid, the counter SHALL increment; at RETRY_GAP cycles the block SHALL return to ISSUE and increment retry_cnt (cache-miss retry).
REQ-012 When a re-issue would exceed MAX_RETRY, the block SHALL instead pulse owner rvalid with err=1, rdata=0, set timeout_err, and go to IDLE.
REQ-013 mem_read_valid in the same cycle as the retry-gap expiry SHALL take priority (data accepted, no re-issue).
REQ-014 mem_read_valid outside WAIT SHALL be ignored.
REQ-015 Read hit latency SHALL be: req/ready at cycle N, mem_read_req at N+1, mem_read_valid at N+2 -> rvalid at N+3.
REQ-016 Counters SHALL be sized $clog2(RETRY_GAP+1) and $clog2(MAX_RETRY+1) bits and SHALL never wrap.

Reset
REQ-017 On rst=1, asynchronously: state=IDLE; last_grant=instruction port (data port wins the first tie); all counters, strobes, rvalid, err, rdata, mem_* outputs, busy and timeout_err SHALL be 0.
REQ-018 Reset asserted mid-transaction SHALL abandon it with no rvalid pulse; timeout_err is cleared only by rst.

Structure
REQ-019 Package mem_arb_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT), the owner enum (OWN_D, OWN_I), and default parameter constants.
REQ-020 The two-way round-robin picker SHALL be the sub-module mem_arb_rr (inputs: two requests, last_grant; output: one-hot grant).

Verification
REQ-021 Data read, addr 0x100, memory returns 0xDEADBEEF on first try -> d_ready at N, mem_read_req at N+1, d_rvalid=1 with d_rdata=0xDEADBEEF at N+3, i_* quiet.
REQ-022 d_req write plus i_req read both high out of reset -> data granted first, mem_write_req once, then i_ready the next IDLE cycle; repeated simultaneous requests alternate D,I,D,I.
REQ-023 Instruction read with no valid for 2*RETRY_GAP cycles, then valid 0x13 -> exactly 3 mem_read_req pulses, i_rvalid with 0x13, i_err=0.
REQ-024 Read never returning valid -> MAX_RETRY+1 strobes, then d_rvalid=1, d_err=1, d_rdata=0, timeout_err stays 1 until rst.
REQ-025 mem_stall=1 during ISSUE for 5 cycles, then rst pulsed during WAIT -> no strobe while stalled; after rst, all outputs 0, state IDLE, no rvalid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default parameters for the memory port arbiter
package mem_arb_pkg;
    localparam int DEF_ADDR_W    = 29;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_RETRY_GAP = 16;
    localparam int DEF_MAX_RETRY = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } owner_t;
endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin picker producing a one-hot grant {i, d}
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       req_d,
    input  logic       req_i,
    input  owner_t     last_grant,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        if (req_d && req_i) begin
            grant = (last_grant == OWN_D) ? 2'b10 : 2'b01;
        end else begin
            grant = {req_i, req_d};
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates data and instruction ports onto a single memory port
// with one outstanding transaction, read retry on missing data and timeout error reporting.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RETRY_GAP = DEF_RETRY_GAP,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read_req,
    output logic              mem_write_req,
    input  logic              mem_read_valid,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_read_ready,
    input  logic              mem_write_ready,
    input  logic              mem_stall,
    output logic              busy,
    output logic              timeout_err
);
    localparam int GW = $clog2(RETRY_GAP + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(RETRY_GAP - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    state_t            state, state_nx;
    owner_t            owner, last_grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [GW-1:0]     wait_cnt;
    logic [RW-1:0]     retry_cnt;
    logic [1:0]        grant;
    logic              req_d_ok, req_i_ok;
    logic              gap_done;
    logic              resp_fire, resp_err;
    logic [DATA_W-1:0] resp_data;

    // A stalled memory side blocks new grants as well as strobes.
    assign req_d_ok = d_req & ~mem_stall;
    assign req_i_ok = i_req & ~mem_stall;

    mem_arb_rr u_rr (
        .req_d      (req_d_ok),
        .req_i      (req_i_ok),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign busy      = (state != IDLE);
    assign mem_en    = busy;
    assign mem_addr  = busy ? addr_q  : '0;
    assign mem_wdata = busy ? wdata_q : '0;
    assign gap_done  = (wait_cnt == GAP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        d_ready       = 1'b0;
        i_ready       = 1'b0;
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        resp_fire     = 1'b0;
        resp_err      = 1'b0;
        resp_data     = '0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    d_ready = grant[0];
                    i_ready = grant[1];
                    if (|grant) state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_stall) begin
                    if (we_q && mem_write_ready) begin
                        mem_write_req = 1'b1;
                        state_nx      = IDLE;
                    end else if (!we_q && mem_read_ready) begin
                        mem_read_req = 1'b1;
                        state_nx     = WAIT;
                    end
                end
            end
            WAIT: begin
                // Returned data wins over a retry-gap expiry in the same cycle.
                if (mem_read_valid) begin
                    resp_fire = 1'b1;
                    resp_data = mem_read_data;
                    state_nx  = IDLE;
                end else if (gap_done) begin
                    if (retry_cnt == RETRY_MAX) begin
                        resp_fire = 1'b1;
                        resp_err  = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        state_nx = ISSUE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner       <= OWN_D;
            last_grant  <= OWN_I;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_cnt    <= '0;
            retry_cnt   <= '0;
            d_rvalid    <= 1'b0;
            d_err       <= 1'b0;
            d_rdata     <= '0;
            i_rvalid    <= 1'b0;
            i_err       <= 1'b0;
            i_rdata     <= '0;
            timeout_err <= 1'b0;
        end else begin
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;
            i_rvalid <= 1'b0;
            i_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        owner      <= grant[1] ? OWN_I : OWN_D;
                        last_grant <= grant[1] ? OWN_I : OWN_D;
                        addr_q     <= grant[1] ? i_addr : d_addr;
                        wdata_q    <= grant[1] ? '0 : d_wdata;
                        we_q       <= grant[0] & d_we;
                        retry_cnt  <= '0;
                    end
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    if (!mem_read_valid) begin
                        if (gap_done) begin
                            wait_cnt <= '0;
                            if (retry_cnt == RETRY_MAX) timeout_err <= 1'b1;
                            else                        retry_cnt   <= retry_cnt + 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (resp_fire) begin
                if (owner == OWN_D) begin
                    d_rvalid <= 1'b1;
                    d_err    <= resp_err;
                    d_rdata  <= resp_data;
                end else begin
                    i_rvalid <= 1'b1;
                    i_err    <= resp_err;
                    i_rdata  <= resp_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW = 29;
    localparam int DW = 32;
    localparam int G  = 4;
    localparam int M  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          d_req = 0, d_we = 0, i_req = 0;
    logic [AW-1:0] d_addr = '0, i_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_read_data = '0;
    logic          mem_read_valid = 0, mem_read_ready = 1, mem_write_ready = 1, mem_stall = 0;
    logic          d_ready, d_rvalid, d_err, i_ready, i_rvalid, i_err;
    logic [DW-1:0] d_rdata, i_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          mem_en, mem_read_req, mem_write_req, busy, timeout_err;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RETRY_GAP(G), .MAX_RETRY(M)) dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .i_req(i_req), .i_addr(i_addr),
        .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .mem_read_valid(mem_read_valid), .mem_read_data(mem_read_data),
        .mem_read_ready(mem_read_ready), .mem_write_ready(mem_write_ready),
        .mem_stall(mem_stall), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_rd = 0, n_wr = 0;
    int gq_own[$], gq_cyc[$], gq_wr[$];
    logic d_rdy_s = 0, i_rdy_s = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction-level reference: one outstanding request, retry windows of G wait cycles.
    bit            m_busy, m_waiting, m_owner, m_we, m_last, m_sticky;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_d_rdata, m_i_rdata;
    bit            m_d_rvalid, m_d_err, m_i_rvalid, m_i_err;
    int            m_waited, m_reissues;

    task automatic deliver(input logic [DW-1:0] data, input bit e);
        if (m_owner == 1'b0) begin m_d_rvalid = 1; m_d_err = e; m_d_rdata = data; end
        else                 begin m_i_rvalid = 1; m_i_err = e; m_i_rdata = data; end
        m_busy = 0;
        m_waiting = 0;
    endtask

    always @(negedge clk) begin
        bit gd, gi, rs, ws;
        if (rst) begin
            m_busy = 0; m_waiting = 0; m_owner = 0; m_we = 0; m_last = 1; m_sticky = 0;
            m_addr = '0; m_wdata = '0; m_d_rdata = '0; m_i_rdata = '0;
            m_d_rvalid = 0; m_d_err = 0; m_i_rvalid = 0; m_i_err = 0;
            m_waited = 0; m_reissues = 0;
        end
        gd = 0; gi = 0;
        if (!rst && !m_busy && !mem_stall) begin
            if (d_req && i_req) begin gd = m_last; gi = !m_last; end
            else begin gd = d_req; gi = i_req; end
        end
        rs = !rst && m_busy && !m_waiting && !m_we && mem_read_ready && !mem_stall;
        ws = !rst && m_busy && !m_waiting &&  m_we && mem_write_ready && !mem_stall;
        chk("d_ready", d_ready, gd);
        chk("i_ready", i_ready, gi);
        chk("mem_read_req", mem_read_req, rs);
        chk("mem_write_req", mem_write_req, ws);
        chk("busy", busy, m_busy);
        chk("mem_en", mem_en, m_busy);
        chk("mem_addr", mem_addr, m_busy ? m_addr : '0);
        chk("mem_wdata", mem_wdata, m_busy ? m_wdata : '0);
        chk("d_rvalid", d_rvalid, m_d_rvalid);
        chk("d_err", d_err, m_d_err);
        chk("d_rdata", d_rdata, m_d_rdata);
        chk("i_rvalid", i_rvalid, m_i_rvalid);
        chk("i_err", i_err, m_i_err);
        chk("i_rdata", i_rdata, m_i_rdata);
        chk("timeout_err", timeout_err, m_sticky);
        if (mem_read_req) n_rd++;
        if (mem_write_req) n_wr++;
        if (d_ready) begin gq_own.push_back(0); gq_cyc.push_back(cyc); gq_wr.push_back(n_wr); end
        if (i_ready) begin gq_own.push_back(1); gq_cyc.push_back(cyc); gq_wr.push_back(n_wr); end
        d_rdy_s = d_ready;
        i_rdy_s = i_ready;
        if (!rst) begin
            m_d_rvalid = 0; m_d_err = 0; m_i_rvalid = 0; m_i_err = 0;
            if (gd || gi) begin
                m_busy = 1; m_waiting = 0; m_reissues = 0; m_owner = gi; m_last = gi;
                m_we = gd ? d_we : 1'b0;
                m_addr = gd ? d_addr : i_addr;
                m_wdata = gd ? d_wdata : '0;
            end else if (m_busy && !m_waiting) begin
                if (ws) m_busy = 0;
                else if (rs) begin m_waiting = 1; m_waited = 0; end
            end else if (m_waiting) begin
                if (mem_read_valid) deliver(mem_read_data, 0);
                else begin
                    m_waited++;
                    if (m_waited == G) begin
                        if (m_reissues == M) begin deliver('0, 1); m_sticky = 1; end
                        else begin m_reissues++; m_waiting = 0; end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic reset_dut();
        rst = 1; d_req = 0; i_req = 0; mem_read_valid = 0; mem_stall = 0;
        mem_read_ready = 1; mem_write_ready = 1;
        step();
        rst = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, gb, k;
        bit seen;
        repeat (2) step();
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_timeout", timeout_err, 0);
        step();
        rst = 0;

        // Data read hit at 0x100
        d_req = 1; d_we = 0; d_addr = 'h100;
        @(negedge clk); chk("t1_d_ready_N", d_ready, 1); chk("t1_i_ready_N", i_ready, 0);
        step(); d_req = 0;
        @(negedge clk); chk("t1_strobe_N1", mem_read_req, 1); chk("t1_addr_N1", mem_addr, 'h100);
        step(); mem_read_valid = 1; mem_read_data = 32'hDEADBEEF;
        @(negedge clk); chk("t1_no_rvalid_N2", d_rvalid, 0);
        step(); mem_read_valid = 0;
        @(negedge clk); chk("t1_rvalid_N3", d_rvalid, 1); chk("t1_rdata_N3", d_rdata, 32'hDEADBEEF);
        chk("t1_i_quiet", i_rvalid, 0);
        step();

        // Simultaneous requests alternate D, I, D, I
        reset_dut();
        gb = gq_own.size();
        d_req = 1; d_we = 1; d_addr = 'h20; d_wdata = 32'h1234_5678;
        i_req = 1; i_addr = 'h40; mem_read_valid = 1; mem_read_data = 32'h0BAD_F00D;
        repeat (24) step();
        d_req = 0; i_req = 0;
        repeat (6) step();
        mem_read_valid = 0;
        chk("t2_grant_count", gq_own.size() - gb >= 4, 1);
        if (gq_own.size() - gb >= 4) begin
            chk("t2_g0_d", gq_own[gb], 0);
            chk("t2_g1_i", gq_own[gb+1], 1);
            chk("t2_g2_d", gq_own[gb+2], 0);
            chk("t2_g3_i", gq_own[gb+3], 1);
            chk("t2_i_two_after_d", gq_cyc[gb+1] - gq_cyc[gb], 2);
            chk("t2_one_write", gq_wr[gb+1] - gq_wr[gb], 1);
        end

        // Instruction read recovered on the third issue
        reset_dut();
        rb = n_rd; i_req = 1; i_addr = 'h55;
        k = 0;
        while (n_rd - rb < 3 && k < 200) begin
            @(negedge clk); seen = i_rdy_s;
            step(); if (seen) i_req = 0;
            k++;
        end
        chk("t3_three_issues_bounded", k < 200, 1);
        mem_read_valid = 1; mem_read_data = 32'h13;
        step(); mem_read_valid = 0;
        @(negedge clk);
        chk("t3_i_rvalid", i_rvalid, 1); chk("t3_i_rdata", i_rdata, 32'h13);
        chk("t3_i_err", i_err, 0); chk("t3_strobes", n_rd - rb, 3);
        step();

        // Read that never returns times out
        reset_dut();
        rb = n_rd; d_req = 1; d_we = 0; d_addr = 'h77;
        @(negedge clk); chk("t4_d_ready", d_ready, 1);
        step(); d_req = 0;
        seen = 0; k = 0;
        while (!seen && k < 300) begin
            @(negedge clk);
            if (d_rvalid) begin
                seen = 1;
                chk("t4_d_err", d_err, 1); chk("t4_d_rdata", d_rdata, 0);
                chk("t4_timeout", timeout_err, 1); chk("t4_strobes", n_rd - rb, M + 1);
            end
            step(); k++;
        end
        chk("t4_rvalid_seen", seen, 1);
        repeat (10) step();
        @(negedge clk); chk("t4_timeout_sticky", timeout_err, 1); chk("t4_idle", busy, 0);
        step();
        reset_dut();
        @(negedge clk); chk("t4_timeout_cleared", timeout_err, 0);
        step();

        // Stall during ISSUE, then reset during WAIT
        d_req = 1; d_we = 0; d_addr = 'h99;
        @(negedge clk); chk("t5_d_ready", d_ready, 1);
        step(); d_req = 0; mem_stall = 1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk); chk("t5_no_strobe_stalled", mem_read_req, 0); chk("t5_busy", busy, 1);
            step();
        end
        mem_stall = 0;
        @(negedge clk); chk("t5_strobe_after_stall", mem_read_req, 1);
        step();
        step(); rst = 1;
        @(negedge clk);
        chk("t5_rst_busy", busy, 0); chk("t5_rst_mem_en", mem_en, 0);
        chk("t5_rst_addr", mem_addr, 0); chk("t5_rst_rvalid", d_rvalid, 0);
        step(); rst = 0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk); chk("t5_no_rvalid_after_rst", d_rvalid, 0); chk("t5_idle_after_rst", busy, 0);
            step();
        end

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            if (!d_req || d_rdy_s) begin
                d_req = ($urandom_range(0, 2) == 0); d_we = 1'($urandom);
                d_addr = AW'($urandom); d_wdata = $urandom;
            end
            if (!i_req || i_rdy_s) begin
                i_req = ($urandom_range(0, 2) == 0); i_addr = AW'($urandom);
            end
            mem_stall = ($urandom_range(0, 9) == 0);
            mem_read_ready = ($urandom_range(0, 3) != 0);
            mem_write_ready = ($urandom_range(0, 3) != 0);
            mem_read_valid = ($urandom_range(0, 5) == 0);
            mem_read_data = $urandom;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0;
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
